// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned STATE_W     = 3;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HOLD = 3'd2,
    ST_DROP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fsm.sv
// Fetch control FSM: state register, next-state logic and request/valid decode.
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall_i,
  input  logic   imem_ack_i,
  input  logic   redirect_valid_i,
  input  logic   redirect_misaligned_i,
  input  logic   misaligned_sticky_i,
  input  logic   inst_ready_i,
  output state_e state_o,
  output logic   imem_req_o,
  output logic   inst_valid_o
);

  state_e state_q, state_d;
  logic   bad_redirect_c;

  assign bad_redirect_c = redirect_valid_i && redirect_misaligned_i;
  assign state_o        = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Redirect outranks ack, ready and stall in every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bad_redirect_c)  state_d = ST_HALT;
        else if (!stall_i)   state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid_i) begin
          if (bad_redirect_c)  state_d = ST_HALT;
          else if (imem_ack_i) state_d = ST_IDLE;
          else                 state_d = ST_DROP;
        end else if (imem_ack_i) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid_i)  state_d = bad_redirect_c ? ST_HALT : ST_IDLE;
        else if (inst_ready_i) state_d = stall_i ? ST_IDLE : ST_REQ;
      end
      ST_DROP: begin
        // A misaligned target seen while draining halts only once the bus is free.
        if (imem_ack_i) state_d = (misaligned_sticky_i || bad_redirect_c) ? ST_HALT : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o   = 1'b0;
    inst_valid_o = 1'b0;
    unique case (state_q)
      ST_REQ, ST_DROP: imem_req_o   = 1'b1;
      ST_HOLD:         inst_valid_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, request address and held-instruction datapath.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misaligned
);

  state_e          state;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            mis_q, mis_d;
  logic            redirect_act_c;

  fetch_fsm u_fsm (
    .clk                   (clk),
    .rst                   (rst),
    .stall_i               (stall),
    .imem_ack_i            (imem_ack),
    .redirect_valid_i      (redirect_valid),
    .redirect_misaligned_i (is_misaligned(redirect_pc)),
    .misaligned_sticky_i   (mis_q),
    .inst_ready_i          (inst_ready),
    .state_o               (state),
    .imem_req_o            (imem_req),
    .inst_valid_o          (inst_valid)
  );

  assign redirect_act_c = redirect_valid && (state != ST_HALT);

  always_comb begin
    pc_d   = pc_q;
    addr_d = addr_q;
    data_d = data_q;
    ipc_d  = ipc_q;
    mis_d  = mis_q;
    if (redirect_act_c) begin
      pc_d = redirect_pc;
      if (is_misaligned(redirect_pc)) mis_d = 1'b1;
    end else if (state == ST_REQ && imem_ack) begin
      pc_d   = pc_q + XLEN'(INSTR_BYTES);
      data_d = imem_rdata;
      ipc_d  = pc_q;
    end
    // The bus address is frozen while a request is outstanding, even across a redirect.
    if (state != ST_REQ && state != ST_DROP) addr_d = pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      data_q <= '0;
      ipc_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ipc_q  <= ipc_d;
      mis_q  <= mis_d;
    end
  end

  assign imem_addr  = addr_q;
  assign inst_data  = data_q;
  assign inst_pc    = ipc_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misaligned     (misaligned)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0;
    stall = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    checks++; if ({imem_req, inst_valid, misaligned} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b expected %b", {imem_req, inst_valid, misaligned}, 3'b000); end
    checks++; if (imem_addr !== 32'h0) begin errors++;
      $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
    checks++; if ({inst_data, inst_pc} !== 64'h0) begin errors++;
      $display("FAIL reset_inst: got %h expected %h", {inst_data, inst_pc}, 64'h0); end
    rst = 1'b0;
    #2;
    checks++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL reset_release_req: got %b expected %b", imem_req, 1'b0); end
    step();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++;
      $display("FAIL first_req: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h0); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    inst_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      exp = 32'(i * 4);
      checks++; if ({imem_req, inst_valid, imem_addr} !== {1'b1, 1'b0, exp}) begin errors++;
        $display("FAIL stream_req%0d: got %b%b/%h expected 10/%h", i, imem_req, inst_valid, imem_addr, exp); end
      imem_ack = 1'b1; imem_rdata = 32'hA000_0000 | exp;
      step();
      imem_ack = 1'b0;
      checks++; if ({inst_valid, imem_req, inst_pc, inst_data} !== {1'b1, 1'b0, exp, 32'hA000_0000 | exp}) begin errors++;
        $display("FAIL stream_hold%0d: got %b%b pc=%h data=%h expected 10 pc=%h", i, inst_valid, imem_req, inst_pc, inst_data, exp); end
      step();
    end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin errors++;
      $display("FAIL stream_next: got %b/%h expected 1/%h", imem_req, imem_addr, 32'hC); end
  endtask

  task automatic test_delayed_ack();
    do_reset();
    inst_ready = 1'b1;
    step();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0011;
    step();
    imem_ack = 1'b0; inst_ready = 1'b0;
    step();
    checks++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h0, 32'h11}) begin errors++;
      $display("FAIL hold_stable: got %b pc=%h data=%h expected 1 pc=0 data=11", inst_valid, inst_pc, inst_data); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin errors++;
        $display("FAIL delay_addr%0d: got %b/%h expected 1/%h", k, imem_req, imem_addr, 32'h4); end
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    checks++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h4, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL delay_hold: got %b pc=%h data=%h expected 1 pc=4 data=deadbeef", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_redirect_req();
    do_reset();
    inst_ready = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'h5;
      step();
      imem_ack = 1'b0;
      step();
    end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin errors++;
      $display("FAIL redir_pre: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h8); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if ({imem_req, inst_valid, imem_addr} !== {1'b1, 1'b0, 32'h8}) begin errors++;
        $display("FAIL drop_addr%0d: got %b%b/%h expected 10/%h", k, imem_req, inst_valid, imem_addr, 32'h8); end
      if (k == 1) begin imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; end
      step();
    end
    imem_ack = 1'b0;
    checks++; if ({imem_req, inst_valid} !== 2'b00) begin errors++;
      $display("FAIL drop_discard: got %b expected %b", {imem_req, inst_valid}, 2'b00); end
    step();
    checks++; if ({imem_req, inst_valid, imem_addr} !== {1'b1, 1'b0, 32'h100}) begin errors++;
      $display("FAIL redir_target: got %b%b/%h expected 10/%h", imem_req, inst_valid, imem_addr, 32'h100); end
  endtask

  task automatic test_redirect_with_ack();
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h200; imem_ack = 1'b1; imem_rdata = 32'h55;
    step();
    clear_inputs();
    checks++; if ({imem_req, inst_valid} !== 2'b00) begin errors++;
      $display("FAIL redir_ack_discard: got %b expected %b", {imem_req, inst_valid}, 2'b00); end
    step();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin errors++;
      $display("FAIL redir_ack_target: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h200); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    step();
    imem_ack = 1'b1; imem_rdata = 32'hC0;
    step();
    imem_ack = 1'b0;
    checks++; if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) begin errors++;
      $display("FAIL flush_pre: got %b/%h expected 1/%h", inst_valid, inst_pc, 32'h0); end
    redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++; if ({inst_valid, imem_req} !== 2'b00) begin errors++;
      $display("FAIL flush_valid: got %b expected %b", {inst_valid, imem_req}, 2'b00); end
    step();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin errors++;
      $display("FAIL flush_target: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h40); end
    imem_ack = 1'b1; imem_rdata = 32'hC40;
    step();
    imem_ack = 1'b0;
    checks++; if ({inst_valid, inst_pc, inst_data} !== {1'b1, 32'h40, 32'hC40}) begin errors++;
      $display("FAIL flush_next: got %b pc=%h data=%h expected 1 pc=40 data=c40", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_wrap_stall();
    do_reset();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL stall_idle: got %b expected %b", imem_req, 1'b0); end
    stall = 1'b0;
    step();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin errors++;
      $display("FAIL idle_redir: got %b/%h expected 1/%h", imem_req, imem_addr, 32'hFFFF_FFFC); end
    imem_ack = 1'b1; imem_rdata = 32'hF0;
    step();
    imem_ack = 1'b0;
    checks++; if ({inst_valid, inst_pc} !== {1'b1, 32'hFFFF_FFFC}) begin errors++;
      $display("FAIL wrap_hold: got %b/%h expected 1/%h", inst_valid, inst_pc, 32'hFFFF_FFFC); end
    inst_ready = 1'b1; stall = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++; if ({imem_req, inst_valid} !== 2'b00) begin errors++;
      $display("FAIL hold_stall: got %b expected %b", {imem_req, inst_valid}, 2'b00); end
    stall = 1'b0;
    step();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++;
      $display("FAIL wrap_addr: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h0); end
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    checks++; if ({imem_req, inst_valid, misaligned} !== 3'b001) begin errors++;
      $display("FAIL mis_halt: got %b expected %b", {imem_req, inst_valid, misaligned}, 3'b001); end
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'b1; inst_ready = 1'b1; stall = 1'b0;
      redirect_valid = (k % 2) == 1; redirect_pc = 32'h200;
      step();
      checks++; if ({imem_req, inst_valid, misaligned} !== 3'b001) begin errors++;
        $display("FAIL mis_stuck%0d: got %b expected %b", k, {imem_req, inst_valid, misaligned}, 3'b001); end
    end
    rst = 1'b1;
    #1;
    checks++; if (misaligned !== 1'b0) begin errors++;
      $display("FAIL mis_clear: got %b expected %b", misaligned, 1'b0); end
    do_reset();
  endtask

  task automatic test_drop_misaligned();
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    checks++; if ({imem_req, misaligned, imem_addr} !== {1'b1, 1'b1, 32'h0}) begin errors++;
      $display("FAIL drop_mis: got %b%b/%h expected 11/%h", imem_req, misaligned, imem_addr, 32'h0); end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    checks++; if ({imem_req, inst_valid, misaligned} !== 3'b001) begin errors++;
      $display("FAIL drop_mis_halt: got %b expected %b", {imem_req, inst_valid, misaligned}, 3'b001); end
  endtask

  task automatic test_reset_mid_drop();
    do_reset();
    inst_ready = 1'b1;
    step();
    imem_ack = 1'b1; imem_rdata = 32'h1;
    step();
    imem_ack = 1'b0;
    step();
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin errors++;
      $display("FAIL mid_drop_pre: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h4); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({imem_req, inst_valid, imem_addr} !== {1'b0, 1'b0, 32'h0}) begin errors++;
      $display("FAIL async_rst: got %b%b/%h expected 00/%h", imem_req, inst_valid, imem_addr, 32'h0); end
    imem_ack = 1'b1; imem_rdata = 32'hE; stall = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if ({imem_req, inst_valid} !== 2'b00) begin errors++;
        $display("FAIL late_ack%0d: got %b expected %b", k, {imem_req, inst_valid}, 2'b00); end
    end
    stall = 1'b0; imem_ack = 1'b0;
    step();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++;
      $display("FAIL post_rst_pc: got %b/%h expected 1/%h", imem_req, imem_addr, 32'h0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_delayed_ack();
    test_redirect_req();
    test_redirect_with_ack();
    test_redirect_hold();
    test_wrap_stall();
    test_misaligned();
    test_drop_misaligned();
    test_reset_mid_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 Port imem_req  output  1  SHALL request an instruction-memory read.
REQ-005 Port imem_addr  output  32  SHALL carry the read address while imem_req=1.
REQ-006 Port imem_ack  input  1  SHALL mark imem_rdata valid in the same cycle; it is meaningful only while imem_req=1.
REQ-007 Port imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-008 Port redirect_valid  input  1  SHALL be a one-cycle branch or jump redirect strobe.
REQ-009 Port redirect_pc  input  32  SHALL carry the redirect target.
REQ-010 Port stall  input  1  SHALL block issue of a new fetch while high.
REQ-011 Port inst_valid  output  1  SHALL indicate that inst_data and inst_pc hold a valid instruction.
REQ-012 Port inst_ready  input  1  SHALL indicate that decode accepts the instruction.
REQ-013 Port inst_data  output  32  SHALL carry the held instruction word.
REQ-014 Port inst_pc  output  32  SHALL carry the address of the held instruction.
REQ-015 Port misaligned  output  1  SHALL be a sticky error flag for a redirect target that is not word-aligned.

Function
REQ-016 States SHALL be IDLE, REQ, HOLD, DROP and HALT; imem_req=1 only in REQ and DROP, and inst_valid=1 only in HOLD.
REQ-017 IDLE SHALL go to REQ when stall=0, and SHALL stay in IDLE otherwise.
REQ-018 In REQ, imem_addr SHALL equal pc and SHALL stay stable until imem_ack.
REQ-019 In REQ with imem_ack=1 and no redirect, the block SHALL load inst_data=imem_rdata and inst_pc=pc, set pc=pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), and go to HOLD.
REQ-020 In REQ with redirect_valid=1 and imem_ack=0, the block SHALL load pc=redirect_pc and go to DROP; the address already on the bus SHALL keep being driven.
REQ-021 In REQ with redirect_valid=1 and imem_ack=1 in the same cycle, the block SHALL discard the returned data, load pc=redirect_pc, and go to IDLE.
REQ-022 In DROP, imem_addr SHALL keep the pre-redirect address (internal register), and imem_ack SHALL discard the data and send the block to IDLE.
REQ-023 In HOLD, inst_valid=1 and inst_data and inst_pc SHALL stay stable until they are accepted or flushed.
REQ-024 In HOLD with inst_ready=1 and no redirect, the block SHALL go to REQ if stall=0, else to IDLE.
REQ-025 In HOLD with redirect_valid=1, the held instruction SHALL be flushed (inst_valid=0 next cycle, even if inst_ready=1), pc SHALL load redirect_pc, and the block SHALL go to IDLE.
REQ-026 Redirect SHALL take priority over inst_ready, imem_ack and stall in every state.
REQ-027 A redirect_valid in IDLE SHALL load pc=redirect_pc and the block SHALL remain subject to REQ-017.
REQ-028 A redirect_valid in DROP SHALL overwrite pc with the newest target and the block SHALL remain in DROP.
REQ-029 A redirect_valid with redirect_pc[1:0]!=0 SHALL set misaligned=1 and send the block to HALT, except in DROP, where it SHALL set misaligned=1 and the block SHALL go to HALT on imem_ack.
REQ-030 HALT SHALL drive imem_req=0 and inst_valid=0 and ignore all inputs until reset.
REQ-031 Minimum throughput SHALL be one instruction per 2 cycles (REQ with ack, then HOLD with ready).

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0 and misaligned=0.
REQ-033 A reset asserted mid-REQ or mid-DROP SHALL abandon the outstanding request; any ack arriving after reset SHALL be ignored because imem_req=0.
REQ-034 The first request after reset release SHALL appear no earlier than the second rising clk edge.

Structure
REQ-035 The shared package fetch_pkg SHALL hold the state encoding (3-bit, five states), the RESET_PC default and the INSTR_BYTES=4 constant.
REQ-036 One sub-module, fetch_fsm, SHALL hold the state register and the next-state and output-enable logic; the pc and instruction registers SHALL reside in the top level.

Verification
REQ-037 Reset then stall=0, imem_ack on the first REQ cycle, inst_ready=1 -> inst_pc sequence 0x0, 0x4, 0x8, one instruction per 2 cycles.
REQ-038 imem_ack delayed 3 cycles -> imem_addr held at 0x4 for all 3 cycles, then inst_data=imem_rdata and inst_pc=0x4.
REQ-039 Redirect to 0x100 in REQ at address 0x8, ack 2 cycles later -> data discarded, next imem_addr=0x100, no inst_valid for 0x8.
REQ-040 HOLD with inst_ready=1 and redirect to 0x40 in the same cycle -> held instruction not delivered, next fetch at 0x40.
REQ-041 Redirect to 0x102 -> misaligned=1, imem_req=0 permanently, cleared only by rst.
REQ-042 rst pulsed mid-DROP with a late ack -> state IDLE, pc=RESET_PC, no inst_valid generated from the late ack.
